red_pitaya_pfd_freq_meter: RTL and testbench
============================================

// Module: red_pitaya_pfd_freq_meter
// PURPOSE
//  Downstream stage of the CORDIC phase-frequency detector. Consumes its 14-bit {turns,phase} word
//  (4 turn bits, 10 phase bits, one LSB = 1/1024 turn) and unwraps it into a wide phase accumulator.
//  Sums per-cycle phase increments over a programmable 2^N-cycle gate to measure frequency offset.
//  Outputs feed the PID input mux and the scope; configuration comes from the DSP register bus.
// PARAMETERS
//  PHASEBITS  14  width of phase_i (two's complement {turns,phase})
//  ACCBITS    32  width of the unwrapped phase accumulator phase_o
//  SUMBITS    28  width of the internal gate sum; must be >= PHASEBITS+MAXLOG
//  MAXLOG     14  largest legal gate_log2_i value
//  OUTBITS    14  width of freq_o
// PORTS
//  clk_i         in   1           system clock, 125 MHz
//  rst_i         in   1           synchronous reset, active-high
//  phase_i       in   PHASEBITS   signed PFD output, new sample every clock
//  clear_i       in   1           single-cycle pulse: zero accumulator, restart gate
//  gate_log2_i   in   4           gate length = 2^gate_log2_i cycles; values > MAXLOG clamp to MAXLOG
//  out_shift_i   in   5           arithmetic right shift applied to the gate sum before saturation
//  phase_o       out  ACCBITS     signed unwrapped phase, wraps modulo 2^ACCBITS
//  freq_o        out  OUTBITS     signed saturated gate sum, held between updates
//  freq_valid_o  out  1           one-cycle strobe when freq_o updates
//  sat_o         out  1           high while the held freq_o was clipped
// BEHAVIOUR
//  - Reset: all outputs 0, primed=0, last=0, gate counter=0, gate sum=0.
//  - Prime: on the first cycle after reset, last<=phase_i, primed<=1, and no delta is generated.
//  - Stage 1, when primed: delta = phase_i - last, computed in PHASEBITS with modular wrap, then sign-extended.
//    A step from +8191 to -8192 gives delta = +1. last<=phase_i every cycle.
//  - Stage 2: phase_o <= phase_o + sext(delta), wrapping. Latency phase_i -> phase_o is 2 cycles.
//  - Gate:
//    - The counter counts 0..2^G-1, where G is latched at gate start. gate_log2_i and out_shift_i are sampled only at gate start.
//    - sum += sext(delta) each cycle. SUMBITS is sized so the sum cannot overflow.
//  - Gate end, when the counter = 2^G-1:
//    - freq_o <= sat(sum_final >>> shift). sat clips to [-2^(OUTBITS-1), 2^(OUTBITS-1)-1].
//    - sat_o <= clip occurred; freq_valid_o <= 1 for one cycle.
//    - The sum and counter restart the next cycle. The new sum includes that cycle's delta, so no samples are lost.
//  - G=0: gate end occurs every cycle, and freq_o tracks delta with 1 cycle of extra latency.
//  - clear_i: the next cycle has phase_o=0, sum=0, counter=0, and new G/shift latched. last is kept (no reprime).
//    If clear_i coincides with gate end, clear wins: no strobe, and freq_o/sat_o are unchanged.
//  - Reset mid-gate: the partial sum is discarded, and priming repeats.
//  - PFD turn saturation (phase_i frozen at a rail) yields delta = 0, which is legal and needs no special case.
// STRUCTURE
//  - Shared package (red_pitaya_dsp_pkg):
//    - PFD_PHASEBITS=14, PFD_TURNBITS=4.
//    - A saturate function: sat(value, inwidth, outwidth).
//  - One sub-module, red_pitaya_pfd_gate_sum: counter, G/shift latch, sum, end strobe, shifter/saturator.
//  - The top level holds priming, the delta register and the phase accumulator.
// TESTING
//  - Reset, then phase_i constant 100: phase_o = 0 forever; with G=2, freq_o = 0 and freq_valid_o every 4 cycles.
//  - phase_i ramps +3 per cycle from 8000 through the 14-bit wrap, G=4, shift=0:
//    phase_o rises 3 per cycle with no jump, and every strobe shows freq_o = 48.
//  - Ramp -5 per cycle, G=10, shift=0: sum = -5120 -> freq_o = -5120, sat_o = 0.
//    Same with shift=2 -> freq_o = -1280.
//  - Ramp +4000 per cycle, G=4, shift=0: sum = 64000 -> freq_o = 8191, sat_o = 1.
//    Restoring a slow ramp clears sat_o at the next strobe.
//  - clear_i asserted in the exact gate-end cycle: no strobe, freq_o held, and phase_o = 0 the next cycle.
//    The next strobe arrives 2^G cycles later.
//  - Change gate_log2_i from 3 to 6 mid-gate: the current gate still ends after 8 cycles, and the following gates last 64 cycles.
//    rst_i pulse mid-gate: outputs are 0, and the first post-reset sample produces no delta.

Source files
------------

// File: rtl/red_pitaya_dsp_pkg.sv
// Shared constants and helpers for the Red Pitaya DSP chain.
package red_pitaya_dsp_pkg;

    // Width of the CORDIC PFD output word {turns, phase}.
    localparam int PFD_PHASEBITS = 14;
    // Number of whole-turn bits at the top of that word.
    localparam int PFD_TURNBITS  = 4;

    // Clip a signed value, meaningful in its low inwidth bits, to the signed
    // range of outwidth bits. The result is returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] value,
        input int                 inwidth,
        input int                 outwidth
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = (value <<< (64 - inwidth)) >>> (64 - inwidth);
        hi = (64'sd1 <<< (outwidth - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/red_pitaya_pfd_gate_sum.sv
// Gate timer and phase-increment summer. Sums deltas over 2^G valid cycles,
// then shifts, saturates and publishes the result with a one-cycle strobe.
import red_pitaya_dsp_pkg::*;

module red_pitaya_pfd_gate_sum #(
    parameter int PHASEBITS = PFD_PHASEBITS,
    parameter int SUMBITS   = 28,
    parameter int MAXLOG    = 14,
    parameter int OUTBITS   = 14
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [PHASEBITS-1:0] delta_i,
    input  logic                        delta_valid_i,
    input  logic                        clear_i,
    input  logic        [3:0]           gate_log2_i,
    input  logic        [4:0]           out_shift_i,
    output logic signed [OUTBITS-1:0]   freq_o,
    output logic                        freq_valid_o,
    output logic                        sat_o
);

    logic        [MAXLOG-1:0]  cnt_q;
    logic        [3:0]         g_q;
    logic        [3:0]         g_in;
    logic        [3:0]         eff_g;
    logic        [4:0]         shift_q;
    logic        [4:0]         eff_shift;
    logic signed [SUMBITS-1:0] sum_q;
    logic signed [SUMBITS-1:0] sum_fin;
    logic signed [SUMBITS-1:0] shifted;
    logic        [MAXLOG:0]    span_m1;
    logic signed [63:0]        wide;
    logic signed [63:0]        satv;
    logic                      end_of_gate;
    logic                      clipped;

    // Gate settings in force this cycle (live inputs at gate start), end
    // detection, and the shifted/saturated candidate result.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        g_in      = (gate_log2_i > 4'(MAXLOG)) ? 4'(MAXLOG) : gate_log2_i;
        eff_g     = g_q;
        eff_shift = shift_q;
        if (cnt_q == '0) begin
            eff_g     = g_in;
            eff_shift = out_shift_i;
        end
        span_m1     = ((MAXLOG + 1)'(1) << eff_g) - (MAXLOG + 1)'(1);
        end_of_gate = delta_valid_i && ({1'b0, cnt_q} == span_m1);
        sum_fin     = sum_q + {{(SUMBITS - PHASEBITS){delta_i[PHASEBITS-1]}}, delta_i};
        shifted     = sum_fin >>> eff_shift;
        wide        = {{(64 - SUMBITS){shifted[SUMBITS-1]}}, shifted};
        satv        = sat(wide, SUMBITS, OUTBITS);
        clipped     = (satv != wide);
    end

    // Counter, setting latch, running sum and published result.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            cnt_q        <= '0;
            g_q          <= '0;
            shift_q      <= '0;
            sum_q        <= '0;
            freq_o       <= '0;
            freq_valid_o <= 1'b0;
            sat_o        <= 1'b0;
        end else begin
            freq_valid_o <= 1'b0;
            if (clear_i) begin
                // Clear beats a coincident gate end: result and flag hold.
                cnt_q   <= '0;
                sum_q   <= '0;
                g_q     <= g_in;
                shift_q <= out_shift_i;
            end else if (delta_valid_i) begin
                if (cnt_q == '0) begin
                    g_q     <= eff_g;
                    shift_q <= eff_shift;
                end
                if (end_of_gate) begin
                    cnt_q        <= '0;
                    sum_q        <= '0;
                    freq_o       <= satv[OUTBITS-1:0];
                    sat_o        <= clipped;
                    freq_valid_o <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    sum_q <= sum_fin;
                end
            end
        end
    end

endmodule

// File: rtl/red_pitaya_pfd_freq_meter.sv
// PFD phase unwrapper and frequency meter: turns the wrapping 14-bit
// {turns,phase} word into a wide phase accumulator and a gated frequency sum.
import red_pitaya_dsp_pkg::*;

module red_pitaya_pfd_freq_meter #(
    parameter int PHASEBITS = PFD_PHASEBITS,
    parameter int ACCBITS   = 32,
    parameter int SUMBITS   = 28,
    parameter int MAXLOG    = 14,
    parameter int OUTBITS   = 14
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [PHASEBITS-1:0] phase_i,
    input  logic                        clear_i,
    input  logic        [3:0]           gate_log2_i,
    input  logic        [4:0]           out_shift_i,
    output logic signed [ACCBITS-1:0]   phase_o,
    output logic signed [OUTBITS-1:0]   freq_o,
    output logic                        freq_valid_o,
    output logic                        sat_o
);

    logic                        primed_q;
    logic signed [PHASEBITS-1:0] last_q;
    logic signed [PHASEBITS-1:0] diff;
    logic signed [PHASEBITS-1:0] delta_q;
    logic                        delta_valid_q;

    // Modular difference: a +8191 -> -8192 step wraps to +1.
    assign diff = phase_i - last_q;

    // Priming, delta register and unwrapped phase accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            primed_q      <= 1'b0;
            last_q        <= '0;
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
            phase_o       <= '0;
        end else begin
            last_q        <= phase_i;
            primed_q      <= 1'b1;
            delta_q       <= primed_q ? diff : '0;
            delta_valid_q <= primed_q;
            if (clear_i) begin
                phase_o <= '0;
            end else begin
                phase_o <= phase_o + {{(ACCBITS - PHASEBITS){delta_q[PHASEBITS-1]}}, delta_q};
            end
        end
    end

    red_pitaya_pfd_gate_sum #(
        .PHASEBITS (PHASEBITS),
        .SUMBITS   (SUMBITS),
        .MAXLOG    (MAXLOG),
        .OUTBITS   (OUTBITS)
    ) u_gate_sum (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .delta_i       (delta_q),
        .delta_valid_i (delta_valid_q),
        .clear_i       (clear_i),
        .gate_log2_i   (gate_log2_i),
        .out_shift_i   (out_shift_i),
        .freq_o        (freq_o),
        .freq_valid_o  (freq_valid_o),
        .sat_o         (sat_o)
    );

endmodule

// File: tb/tb_red_pitaya_pfd_freq_meter.sv
// Directed self-checking bench for the PFD phase unwrapper / frequency meter.
module tb_red_pitaya_pfd_freq_meter;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               clear_i;
    logic signed [13:0] phase_i;
    logic        [3:0]  gate_log2;
    logic        [4:0]  out_shift;
    logic signed [31:0] phase_o;
    logic signed [13:0] freq_o;
    logic               freq_valid_o;
    logic               sat_o;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] ph;
    int          inc;
    int          n;
    int          strobes;
    int          last_strobe;

    red_pitaya_pfd_freq_meter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .phase_i      (phase_i),
        .clear_i      (clear_i),
        .gate_log2_i  (gate_log2),
        .out_shift_i  (out_shift),
        .phase_o      (phase_o),
        .freq_o       (freq_o),
        .freq_valid_o (freq_valid_o),
        .sat_o        (sat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: present the current ramp value, sample just after the edge.
    task automatic cyc();
        phase_i = ph;
        @(posedge clk);
        #1;
        ph = 14'(int'(ph) + inc);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Run until a strobe or until the budget expires; cycles used in cnt.
    task automatic wait_strobe(input string tag, input int max, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!freq_valid_o && cnt < max);
        check(tag, freq_valid_o, 1);
    endtask

    initial begin
        rst_i     = 1'b1;
        clear_i   = 1'b0;
        ph        = 14'd100;
        inc       = 0;
        gate_log2 = 4'd2;
        out_shift = 5'd0;

        // Constant input, G=2.
        do_reset();
        check("rst_phase", phase_o, 0);
        check("rst_freq", freq_o, 0);
        check("rst_valid", freq_valid_o, 0);
        check("rst_sat", sat_o, 0);
        strobes     = 0;
        last_strobe = 2;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("const_phase", phase_o, 0);
            if (freq_valid_o) begin
                strobes++;
                check("const_spacing", i - last_strobe, 4);
                check("const_freq", freq_o, 0);
                last_strobe = i;
            end
        end
        check("const_strobes", strobes, 4);

        // +3 ramp across the 14-bit wrap, G=4.
        ph        = 14'd8000;
        inc       = 3;
        gate_log2 = 4'd4;
        do_reset();
        strobes = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            check("ramp3_phase", phase_o, (i >= 2) ? 3 * (i - 2) : 0);
            if (freq_valid_o) begin
                strobes++;
                check("ramp3_freq", freq_o, 48);
                check("ramp3_sat", sat_o, 0);
            end
        end
        check("ramp3_strobes", strobes, 6);

        // -5 ramp, G=10, shift 0 then 2.
        ph        = 14'd0;
        inc       = -5;
        gate_log2 = 4'd10;
        out_shift = 5'd0;
        do_reset();
        wait_strobe("neg_strobe1", 2000, n);
        check("neg_first_at", n, 1026);
        check("neg_freq", freq_o, -5120);
        check("neg_sat", sat_o, 0);
        out_shift = 5'd2;
        cyc();
        check("neg_valid_pulse", freq_valid_o, 0);
        wait_strobe("neg_strobe2", 2000, n);
        check("neg_spacing", n, 1023);
        check("neg_freq_shift2", freq_o, -1280);

        // Saturation at +4000 per cycle, then a slow ramp releases it.
        ph        = 14'd0;
        inc       = 4000;
        gate_log2 = 4'd4;
        out_shift = 5'd0;
        do_reset();
        wait_strobe("sat_strobe1", 100, n);
        check("sat_first_at", n, 18);
        check("sat_freq", freq_o, 8191);
        check("sat_flag", sat_o, 1);
        inc = 1;
        wait_strobe("sat_strobe2", 100, n);
        check("sat_spacing", n, 16);
        check("unsat_freq", freq_o, 8014);
        check("unsat_flag", sat_o, 0);

        // clear_i in the gate-end cycle, G=3.
        ph        = 14'd50;
        inc       = 2;
        gate_log2 = 4'd3;
        do_reset();
        wait_strobe("clr_strobe1", 100, n);
        check("clr_freq1", freq_o, 16);
        inc = 3;
        for (int i = 0; i < 7; i++) cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        check("clr_no_strobe", freq_valid_o, 0);
        check("clr_freq_held", freq_o, 16);
        check("clr_phase_zero", phase_o, 0);
        wait_strobe("clr_strobe2", 100, n);
        check("clr_next_after", n, 8);
        check("clr_freq2", freq_o, 24);

        // Gate length change mid-gate, then reset mid-gate.
        ph        = 14'd0;
        inc       = 1;
        gate_log2 = 4'd3;
        do_reset();
        wait_strobe("g_strobe1", 100, n);
        check("g_first_at", n, 10);
        for (int i = 0; i < 3; i++) cyc();
        gate_log2 = 4'd6;
        wait_strobe("g_strobe2", 100, n);
        check("g_old_gate_rest", n, 5);
        check("g_freq8", freq_o, 8);
        wait_strobe("g_strobe3", 200, n);
        check("g_new_gate", n, 64);
        check("g_freq64", freq_o, 64);
        for (int i = 0; i < 10; i++) cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("midrst_phase", phase_o, 0);
        check("midrst_freq", freq_o, 0);
        check("midrst_valid", freq_valid_o, 0);
        check("midrst_sat", sat_o, 0);
        cyc();
        check("prime_phase1", phase_o, 0);
        cyc();
        check("prime_phase2", phase_o, 0);
        cyc();
        check("prime_phase3", phase_o, 1);

        // gate_log2 above the maximum clamps to 14.
        ph        = 14'd0;
        inc       = 1;
        gate_log2 = 4'd15;
        out_shift = 5'd2;
        do_reset();
        wait_strobe("clamp_strobe", 20000, n);
        check("clamp_first_at", n, 16386);
        check("clamp_freq", freq_o, 4096);
        check("clamp_sat", sat_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
